// File: rtl/dial_pkg.sv
// dial_pkg: shared types and helpers for the streaming dial-rotation engine.
//   state_e    : engine FSM states (IDLE, RUN, REPORT)
//   CTL_*      : bit positions inside the 6-bit control word
//   AMT_LSB    : lowest bit of the amount field inside a record
//   *_w_f      : derived widths (record, position, lane count) and the direction bit position
package dial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam int CTL_CLEAR  = 0;
  localparam int CTL_MODE   = 1;
  localparam int CTL_REPORT = 2;

  // A record is {dir, amount}; the amount starts at bit 0.
  localparam int AMT_LSB = 0;

  // Record width: direction bit on top of the amount.
  function automatic int rec_w_f(input int amt_w);
    return amt_w + 1;
  endfunction

  // Direction bit sits directly above the amount field.
  function automatic int dir_bit_f(input int amt_w);
    return AMT_LSB + amt_w;
  endfunction

  // Bits needed to hold a dial position 0..modulus-1.
  function automatic int pos_w_f(input int modulus);
    return $clog2(modulus);
  endfunction

  // Bits needed to hold a lane count 0..lanes.
  function automatic int lane_w_f(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/dial_coprocessor_multi_divmod.sv
// divmod_const: combinational split of a rotation amount by the dial modulus.
//   a : rotation amount (AMT_W bits)
//   q : whole turns, a / MODULUS
//   r : residual clicks, a % MODULUS (POS_W bits, always < MODULUS)
// The divisor is a constant, so synthesis reduces this to a fixed network.
module divmod_const
  import dial_pkg::*;
#(
  parameter int AMT_W   = 15,
  parameter int MODULUS = 100,
  localparam int POS_W  = pos_w_f(MODULUS)
) (
  input  logic [AMT_W-1:0] a,
  output logic [AMT_W-1:0] q,
  output logic [POS_W-1:0] r
);

  localparam logic [AMT_W-1:0] DIV = AMT_W'(MODULUS);

  // Quotient and remainder by the constant modulus.
  always_comb begin
    q = a / DIV;
    r = POS_W'(a % DIV);
  end

endmodule

// File: rtl/dial_coprocessor_multi.sv
// dial_coprocessor_multi: streaming dial-rotation engine.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   din        : beat of up to LANES records, record i at din[i*REC_W +: REC_W]
//   din_lanes  : valid records in the beat (values above LANES are clamped)
//   din_valid  : beat offered
//   din_ready  : beat accepted when din_valid && din_ready
//   control    : [0] clear, [1] mode (0 end-at-zero, 1 every-pass), [2] report, [5:3] ignored
//   dout       : {zero pad, count, pos}, held between reports
//   dout_valid : one-cycle pulse qualifying a fresh report
// Records of an accepted beat are applied one per cycle. Clear/report requests
// that arrive while busy are remembered and served once the engine is idle,
// report first when both are pending.
module dial_coprocessor_multi
  import dial_pkg::*;
#(
  parameter int LANES      = 8,
  parameter int AMT_W      = 15,
  parameter int MODULUS    = 100,
  parameter int START_POS  = 50,
  parameter int CNT_W      = 32,
  parameter int WIDTH_DIN  = 128,
  parameter int WIDTH_DOUT = 128,
  localparam int REC_W     = rec_w_f(AMT_W),
  localparam int POS_W     = pos_w_f(MODULUS),
  localparam int LANE_W    = lane_w_f(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DIN-1:0]  din,
  input  logic [LANE_W-1:0]     din_lanes,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [5:0]            control,
  output logic [WIDTH_DOUT-1:0] dout,
  output logic                  dout_valid
);

  localparam int BEAT_W  = LANES * REC_W;
  localparam int DIR_BIT = dir_bit_f(AMT_W);
  localparam int SUM_W   = ((CNT_W > AMT_W + 1) ? CNT_W : AMT_W + 1) + 1;
  localparam logic [POS_W:0]     MOD_X     = (POS_W + 1)'(MODULUS);
  localparam logic [POS_W-1:0]   START_P   = POS_W'(START_POS);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SUM_W-1:0]   CNT_MAX_X = SUM_W'(CNT_MAX);

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [LANE_W-1:0]       lanes_q, lanes_d;
  logic [LANE_W-1:0]       idx_q, idx_d;
  logic                    mode_q, mode_d;
  logic                    pend_clear_q, pend_clear_d;
  logic                    pend_report_q, pend_report_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH_DOUT-1:0]   dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;

  logic [REC_W-1:0]        rec_s;
  logic [AMT_W-1:0]        amt_s;
  logic [AMT_W-1:0]        quo_s;
  logic [POS_W-1:0]        rem_s;
  logic                    dir_s;
  logic [POS_W:0]          sum_s;
  logic                    wrap_s;
  logic                    hit_s;
  logic [POS_W-1:0]        new_pos_s;
  logic [AMT_W:0]          passes_s;
  logic [AMT_W:0]          inc_s;
  logic [SUM_W-1:0]        csum_s;
  logic [CNT_W-1:0]        cnt_next_s;
  logic [LANE_W-1:0]       lanes_clamp_s;
  logic                    accept_s;
  logic                    want_clear_s;
  logic                    want_report_s;
  logic [2:0]              ctl_unused_s;

  assign ctl_unused_s = control[5:3];

  // Ready only from registered state; forced low while reset is asserted.
  assign din_ready  = rst & (state_q == IDLE) & ~pend_report_q & ~pend_clear_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  // Select the record addressed by the lane index.
  always_comb begin
    rec_s = beat_q[REC_W-1:0];
    for (int i = 1; i < LANES; i++) begin
      rec_s = (idx_q == LANE_W'(i)) ? beat_q[i*REC_W +: REC_W] : rec_s;
    end
  end

  assign dir_s = rec_s[DIR_BIT];
  assign amt_s = rec_s[AMT_LSB +: AMT_W];

  divmod_const #(
    .AMT_W   (AMT_W),
    .MODULUS (MODULUS)
  ) u_divmod (
    .a (amt_s),
    .q (quo_s),
    .r (rem_s)
  );

  // New position and zero-event increment for the current record.
  always_comb begin
    sum_s  = {1'b0, pos_q} + {1'b0, rem_s};
    wrap_s = (sum_s >= MOD_X);
    if (dir_s) begin
      new_pos_s = wrap_s ? POS_W'(sum_s - MOD_X) : POS_W'(sum_s);
      hit_s     = wrap_s;
    end else begin
      // Moving left from a position below the residual borrows one turn.
      new_pos_s = (rem_s > pos_q) ? POS_W'({1'b0, pos_q} + MOD_X - {1'b0, rem_s})
                                  : (pos_q - rem_s);
      // Landing on or crossing 0 counts, but leaving 0 does not.
      hit_s     = (pos_q != {POS_W{1'b0}}) && (rem_s >= pos_q);
    end
    passes_s = {1'b0, quo_s} + (AMT_W + 1)'(hit_s);
    // A zero-length record never produces an event, even while parked on 0.
    if (amt_s == {AMT_W{1'b0}}) begin
      inc_s = {(AMT_W + 1){1'b0}};
    end else if (mode_q) begin
      inc_s = passes_s;
    end else begin
      inc_s = (AMT_W + 1)'(new_pos_s == {POS_W{1'b0}});
    end
    csum_s     = SUM_W'(cnt_q) + SUM_W'(inc_s);
    cnt_next_s = (csum_s > CNT_MAX_X) ? CNT_MAX : CNT_W'(csum_s);
  end

  // Next-state logic for the FSM, beat register, counters and outputs.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    lanes_d       = lanes_q;
    idx_d         = idx_q;
    mode_d        = mode_q;
    pend_clear_d  = pend_clear_q;
    pend_report_d = pend_report_q;
    pos_d         = pos_q;
    cnt_d         = cnt_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;

    lanes_clamp_s = (din_lanes > LANE_W'(LANES)) ? LANE_W'(LANES) : din_lanes;
    accept_s      = din_valid & din_ready;
    want_clear_s  = pend_clear_q | control[CTL_CLEAR];
    want_report_s = pend_report_q | control[CTL_REPORT];

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          // The handshake already committed to the beat; requests in the
          // same cycle wait until it has been applied.
          beat_d        = din[BEAT_W-1:0];
          lanes_d       = lanes_clamp_s;
          mode_d        = control[CTL_MODE];
          idx_d         = {LANE_W{1'b0}};
          pend_clear_d  = control[CTL_CLEAR];
          pend_report_d = control[CTL_REPORT];
          state_d       = (lanes_clamp_s != {LANE_W{1'b0}}) ? RUN : IDLE;
        end else if (want_report_s) begin
          // Report the current values; a simultaneous clear is deferred.
          dout_d        = WIDTH_DOUT'({cnt_q, pos_q});
          dout_valid_d  = 1'b1;
          pend_report_d = 1'b0;
          pend_clear_d  = want_clear_s;
          state_d       = REPORT;
        end else if (want_clear_s) begin
          pos_d        = START_P;
          cnt_d        = {CNT_W{1'b0}};
          pend_clear_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        pos_d         = new_pos_s;
        cnt_d         = cnt_next_s;
        idx_d         = idx_q + LANE_W'(1);
        pend_clear_d  = want_clear_s;
        pend_report_d = want_report_s;
        state_d       = (idx_q == lanes_q - LANE_W'(1)) ? IDLE : RUN;
      end
      REPORT: begin
        pend_clear_d  = want_clear_s;
        pend_report_d = want_report_s;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      beat_q        <= {BEAT_W{1'b0}};
      lanes_q       <= {LANE_W{1'b0}};
      idx_q         <= {LANE_W{1'b0}};
      mode_q        <= 1'b0;
      pend_clear_q  <= 1'b0;
      pend_report_q <= 1'b0;
      pos_q         <= START_P;
      cnt_q         <= {CNT_W{1'b0}};
      dout_q        <= {WIDTH_DOUT{1'b0}};
      dout_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      lanes_q       <= lanes_d;
      idx_q         <= idx_d;
      mode_q        <= mode_d;
      pend_clear_q  <= pend_clear_d;
      pend_report_q <= pend_report_d;
      pos_q         <= pos_d;
      cnt_q         <= cnt_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
    end
  end

endmodule

// File: tb/tb_dial_coprocessor_multi.sv
// Testbench for dial_coprocessor_multi: a table of hand-derived rotation streams,
// randomized back-to-back beats against a click-level arithmetic model, and
// hand-written sequences for pending requests, saturation and mid-beat reset.
// A second instance built with CNT_W=4 shares all inputs.
module tb_dial_coprocessor_multi;

  localparam int     M     = 100;
  localparam longint CMAX0 = 64'd4294967295;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic [3:0]   din_lanes;
  logic         din_valid;
  logic [5:0]   control;
  logic         din_ready0, dout_valid0, din_ready1, dout_valid1;
  logic [127:0] dout0, dout1;

  always #5 clk = ~clk;

  dial_coprocessor_multi u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_lanes(din_lanes), .din_valid(din_valid),
    .din_ready(din_ready0), .control(control), .dout(dout0), .dout_valid(dout_valid0)
  );

  dial_coprocessor_multi #(.CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_lanes(din_lanes), .din_valid(din_valid),
    .din_ready(din_ready1), .control(control), .dout(dout1), .dout_valid(dout_valid1)
  );

  typedef struct {
    bit          clr;
    bit          mode;
    int          n;
    logic [15:0] rec [10];
    longint      ecnt;
    longint      epos;
  } vec_t;

  vec_t         vt [10];
  int           nv;
  logic [15:0]  tmp [10];
  logic [15:0]  aoc [10];

  int           n_vec = 0;
  int           n_err = 0;
  longint       m_pos, m_cnt;
  int           pulses;
  logic [127:0] cap0, cap1;

  function automatic logic [15:0] rr(input int a);
    return {1'b1, a[14:0]};
  endfunction

  function automatic logic [15:0] ll(input int a);
    return {1'b0, a[14:0]};
  endfunction

  // Reference: rotate a clicks; count landings on 0 (mode 0) or every time 0 is reached (mode 1).
  function automatic void m_apply(input logic [15:0] r, input bit mode);
    longint a, p, passes, np;
    a = longint'(r[14:0]);
    p = m_pos;
    if (r[15]) begin
      passes = (p + a) / M;
      np     = (p + a) % M;
    end else begin
      np = ((p - a) % M + M) % M;
      if (p == 0)       passes = a / M;
      else if (a >= p)  passes = (a - p) / M + 1;
      else              passes = 0;
    end
    if (a != 0) begin
      m_cnt = m_cnt + (mode ? passes : ((np == 0) ? 1 : 0));
      if (m_cnt > CMAX0) m_cnt = CMAX0;
    end
    m_pos = np;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (din_ready0 !== 1'b1 && k < 500) begin
      next();
      k++;
    end
    if (din_ready0 !== 1'b1) chk("ready_timeout", 64'(din_ready0), 64'd1);
  endtask

  task automatic send_beat(input logic [127:0] beat, input int n, input bit mode);
    int eff;
    wait_ready();
    din       = beat;
    din_lanes = 4'(n);
    din_valid = 1'b1;
    control[1] = mode;
    next();
    din_valid = 1'b0;
    din       = {$urandom, $urandom, $urandom, $urandom};
    din_lanes = 4'($urandom_range(0, 15));
    eff = (n > 8) ? 8 : n;
    for (int k = 0; k < eff; k++) m_apply(beat[k*16 +: 16], mode);
  endtask

  task automatic clear_all();
    wait_ready();
    control[0] = 1'b1;
    next();
    control[0] = 1'b0;
    m_pos = 50;
    m_cnt = 0;
  endtask

  task automatic watch(input int cyc, input string nm);
    pulses = 0;
    cap0 = '0;
    cap1 = '0;
    for (int i = 0; i < cyc; i++) begin
      if (dout_valid0 === 1'b1) begin
        pulses++;
        cap0 = dout0;
        cap1 = dout1;
      end
      next();
    end
    chk({nm, "_pulses"}, 64'(pulses), 64'd1);
  endtask

  task automatic report_check(input string nm, input longint ecnt, input longint epos);
    wait_ready();
    control[2] = 1'b1;
    next();
    control[2] = 1'b0;
    watch(6, nm);
    chk({nm, "_cnt"},  64'(cap0[38:7]), 64'(ecnt));
    chk({nm, "_pos"},  64'(cap0[6:0]),  64'(epos));
    chk({nm, "_hold"}, 64'(dout0[38:0]), 64'((ecnt << 7) | epos));
  endtask

  task automatic add_vec(input bit clr, input bit mode, input int n, input longint ecnt, input longint epos);
    vt[nv].clr  = clr;
    vt[nv].mode = mode;
    vt[nv].n    = n;
    vt[nv].rec  = tmp;
    vt[nv].ecnt = ecnt;
    vt[nv].epos = epos;
    nv++;
  endtask

  task automatic clear_tmp();
    for (int k = 0; k < 10; k++) tmp[k] = 16'h0000;
  endtask

  initial begin
    logic [127:0] beat;
    int           n, eff, k, a;
    bit           mode;
    longint       ec, ep;

    rst = 1'b0; din = '0; din_lanes = '0; din_valid = 1'b0; control = '0;
    m_pos = 50; m_cnt = 0;

    aoc = '{ll(68), ll(30), rr(48), ll(5), rr(60), ll(55), ll(1), ll(99), rr(14), ll(82)};
    nv = 0;
    tmp = aoc;                                          add_vec(1'b1, 1'b0, 10, 3, 32);
    tmp = aoc;                                          add_vec(1'b1, 1'b1, 10, 6, 32);
    clear_tmp(); tmp[0] = rr(1000);                     add_vec(1'b1, 1'b1, 1, 10, 50);
    clear_tmp(); tmp[0] = ll(50);                       add_vec(1'b1, 1'b0, 1, 1, 0);
    clear_tmp(); tmp[0] = ll(50); tmp[1] = rr(0); tmp[2] = ll(0);
                                                        add_vec(1'b1, 1'b0, 3, 1, 0);
    clear_tmp(); tmp[0] = ll(50); tmp[1] = ll(100); tmp[2] = rr(0); tmp[3] = ll(300);
                                                        add_vec(1'b1, 1'b1, 4, 5, 0);
    clear_tmp(); tmp[0] = ll(0); tmp[1] = rr(100); tmp[2] = ll(150);
                                                        add_vec(1'b1, 1'b1, 3, 3, 0);
    clear_tmp(); tmp[0] = rr(32767);                    add_vec(1'b1, 1'b1, 1, 328, 17);
    clear_tmp(); tmp[0] = rr(83);                       add_vec(1'b0, 1'b0, 1, 329, 0);

    // Reset state
    repeat (3) next();
    chk("rst_din_ready",  64'(din_ready0),  64'd0);
    chk("rst_dout_valid", 64'(dout_valid0), 64'd0);
    chk("rst_dout",       64'(dout0[63:0]), 64'd0);
    chk("rst_din_ready1", 64'(din_ready1),  64'd0);
    rst = 1'b1;
    next();
    chk("ready_after_rst", 64'(din_ready0), 64'd1);
    report_check("reset", 0, 50);

    // Table-driven streams
    for (int i = 0; i < nv; i++) begin
      if (vt[i].clr) clear_all();
      for (int b = 0; b < vt[i].n; b += 8) begin
        beat = '0;
        for (int j = 0; j < 8; j++) begin
          if (b + j < vt[i].n) beat[j*16 +: 16] = vt[i].rec[b + j];
        end
        send_beat(beat, ((vt[i].n - b) > 8) ? 8 : (vt[i].n - b), vt[i].mode);
      end
      report_check($sformatf("vec%0d", i), vt[i].ecnt, vt[i].epos);
    end

    // Back-to-back random beats with din_valid held high
    clear_all();
    wait_ready();
    for (int b = 0; b < 40; b++) begin
      n    = $urandom_range(0, 11);
      mode = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) begin
        case ($urandom_range(0, 5))
          0:       a = 0;
          1:       a = 32767;
          2:       a = 100 * $urandom_range(1, 50);
          3:       a = $urandom_range(1, 99);
          default: a = $urandom_range(0, 3000);
        endcase
        beat[j*16 +: 16] = {1'($urandom_range(0, 1)), a[14:0]};
      end
      din = beat; din_lanes = 4'(n); din_valid = 1'b1; control[1] = mode;
      chk($sformatf("bp_ready%0d", b), 64'(din_ready0), 64'd1);
      next();
      eff = (n > 8) ? 8 : n;
      for (int j = 0; j < eff; j++) m_apply(beat[j*16 +: 16], mode);
      k = 0;
      while (din_ready0 !== 1'b1 && k < 20) begin
        din = {$urandom, $urandom, $urandom, $urandom};
        din_lanes = 4'($urandom_range(0, 15));
        next();
        k++;
      end
      chk($sformatf("bp_busy%0d", b), 64'(k), 64'(eff));
    end
    din_valid = 1'b0;
    report_check("bp_final", m_cnt, m_pos);

    // Report and clear pulsed together while a beat is running
    clear_all();
    beat = '0;
    for (int j = 0; j < 8; j++) beat[j*16 +: 16] = aoc[j];
    send_beat(beat, 8, 1'b1);
    control[0] = 1'b1; control[2] = 1'b1;
    next();
    control[0] = 1'b0; control[2] = 1'b0;
    ec = m_cnt; ep = m_pos;
    watch(20, "pend");
    chk("pend_cnt", 64'(cap0[38:7]), 64'(ec));
    chk("pend_pos", 64'(cap0[6:0]),  64'(ep));
    m_pos = 50; m_cnt = 0;
    report_check("pend_after", 0, 50);

    // Saturation on the narrow-counter instance
    clear_all();
    beat = '0; beat[15:0] = rr(1000);
    send_beat(beat, 1, 1'b1);
    report_check("sat_a", 10, 50);
    chk("sat_a_cnt1", 64'(cap1[10:7]), 64'd10);
    beat = '0; beat[15:0] = rr(1600);
    send_beat(beat, 1, 1'b1);
    report_check("sat_b", 26, 50);
    chk("sat_b_cnt1", 64'(cap1[10:7]), 64'd15);
    chk("sat_b_pos1", 64'(cap1[6:0]),  64'd50);
    beat = '0; beat[15:0] = rr(100);
    send_beat(beat, 1, 1'b1);
    report_check("sat_c", 27, 50);
    chk("sat_c_cnt1", 64'(cap1[10:7]), 64'd15);

    // Reset in the middle of a beat
    beat = '0;
    for (int j = 0; j < 8; j++) beat[j*16 +: 16] = rr(1);
    send_beat(beat, 8, 1'b1);
    next(); next();
    rst = 1'b0;
    next();
    chk("mid_rst_ready",  64'(din_ready0),  64'd0);
    chk("mid_rst_valid",  64'(dout_valid0), 64'd0);
    chk("mid_rst_dout",   64'(dout0[63:0]), 64'd0);
    chk("mid_rst_dout1",  64'(dout1[63:0]), 64'd0);
    chk("mid_rst_ready1", 64'(din_ready1),  64'd0);
    rst = 1'b1;
    m_pos = 50; m_cnt = 0;
    report_check("after_rst", 0, 50);
    chk("after_rst_cnt1", 64'(cap1[10:7]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
